hyster_row_feeder: RTL and testbench

Raster-to-column-triple converter that sits directly upstream of `Hyster`. It accepts one 5-bit suppressed-gradient pixel per cycle in raster order and buffers two previous rows. For every column it emits three vertically aligned pixels (top, middle, bottom), together with the `out_valid_o` qualifier that drives `Hyster`'s `enable_i`. Row and frame boundaries are flagged so the hysteresis stage can be re-armed per strip.

---
 rtl/hyster_pkg.sv | 19 +
 rtl/hyster_line_ram.sv | 39 +++
 rtl/hyster_row_feeder.sv | 203 ++++++++++++++++++++
 tb/tb_hyster_row_feeder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hyster_pkg.sv
// hyster_pkg: definitions shared by the Hyster front-end blocks.
//   PIX_W          : width of one suppressed-gradient pixel
//   pix_t          : pixel type
//   feeder_state_t : state encoding of the row feeder FSM
package hyster_pkg;

  localparam int PIX_W = 5;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/hyster_line_ram.sv
// hyster_line_ram: one line bank of DEPTH x WIDTH, simple dual port.
// A read at the address being written returns the word as it was before
// the write (read-old-data). The read port is combinational, so the
// consumer's output register captures the old word on the same edge that
// commits the write.
// Ports:
//   clk_p_i   : clock, rising edge
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_addr_i : read address
//   rd_data_o : read data (old contents at rd_addr_i)
module hyster_line_ram
  import hyster_pkg::*;
#(
  parameter int DEPTH = 906,
  parameter int WIDTH = 5,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_p_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are never cleared, the FILL rows overwrite them.
  always_ff @(posedge clk_p_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/hyster_row_feeder.sv
// hyster_row_feeder: raster pixels in, vertically aligned column triples
// out (top = oldest row, bottom = current row) for the Hyster stage.
// Two line banks form a ping-pong pair; top_sel_q names the bank holding
// the older row, which is also the one the incoming pixel overwrites.
// Optional feature macro: HYSTER_FEEDER_ROWPAD_EN -- zero-pads one row
// above and below the frame (row 1 emits {0,r0,r1}, a FLUSH phase emits
// {r(H-2),r(H-1),0}), giving IMG_H strips per frame instead of IMG_H-2.
// Ports:
//   clk_p_i, reset_n_i        : clock (rising), async active-low reset
//   in_pixel_i, in_valid_i    : raster pixel and its qualifier
//   in_ready_o                : accept; transfer = in_valid_i & in_ready_o
//   pixel_out0/1/2_o          : top / middle / bottom pixel of a column
//   out_valid_o               : triple valid this cycle
//   strip_end_o               : triple is the last column of its strip
//   frame_done_o              : one-cycle pulse after the frame's last triple
module hyster_row_feeder #(
  parameter int IMG_W = 906,
  parameter int IMG_H = 300,
  parameter int PIX_W = 5
) (
  input  logic             clk_p_i,
  input  logic             reset_n_i,
  input  logic [PIX_W-1:0] in_pixel_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [PIX_W-1:0] pixel_out0_o,
  output logic [PIX_W-1:0] pixel_out1_o,
  output logic [PIX_W-1:0] pixel_out2_o,
  output logic             out_valid_o,
  output logic             strip_end_o,
  output logic             frame_done_o
);
  import hyster_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]    ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0]    ROW_ONE  = RW'(1);
  localparam logic [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};

  feeder_state_t    state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic             top_sel_q, top_sel_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             strip_end_q, strip_end_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] pix0_q, pix0_d, pix1_q, pix1_d, pix2_q, pix2_d;

  logic             accept_s, col_last_s, row_last_s, wrap_s;
  logic             stream_emit_s, pad_top_s, flush_s;
  logic [PIX_W-1:0] bank0_rd_s, bank1_rd_s, top_rd_s, mid_rd_s;

  assign accept_s   = in_valid_i & in_ready_q;
  assign col_last_s = (col_q == COL_LAST);
  assign row_last_s = (row_q == ROW_LAST);
  assign wrap_s     = accept_s & col_last_s;
  assign top_rd_s   = top_sel_q ? bank1_rd_s : bank0_rd_s;
  assign mid_rd_s   = top_sel_q ? bank0_rd_s : bank1_rd_s;

  hyster_line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_bank0 (
    .clk_p_i   (clk_p_i),
    .wr_en_i   (accept_s & ~top_sel_q),
    .wr_addr_i (col_q),
    .wr_data_i (in_pixel_i),
    .rd_addr_i (col_q),
    .rd_data_o (bank0_rd_s)
  );

  hyster_line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_bank1 (
    .clk_p_i   (clk_p_i),
    .wr_en_i   (accept_s & top_sel_q),
    .wr_addr_i (col_q),
    .wr_data_i (in_pixel_i),
    .rd_addr_i (col_q),
    .rd_data_o (bank1_rd_s)
  );

  // Emission qualifiers; the padding paths exist only with the pad feature.
  always_comb begin
    stream_emit_s = accept_s && (state_q == STREAM);
`ifdef HYSTER_FEEDER_ROWPAD_EN
    pad_top_s = accept_s && (state_q == FILL) && (row_q == ROW_ONE);
    flush_s   = (state_q == FLUSH);
`else
    pad_top_s = 1'b0;
    flush_s   = 1'b0;
`endif
  end

  // Next-state logic: counters, bank select and FSM transitions.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    top_sel_d = top_sel_q;
    if (accept_s) begin
      if (col_last_s) begin
        col_d     = {CW{1'b0}};
        top_sel_d = ~top_sel_q;
        if (row_last_s) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (state_q == FLUSH) begin
      // FLUSH walks the columns on its own, reading without writing.
      if (col_last_s) begin
        col_d = {CW{1'b0}};
      end else begin
        col_d = col_q + 1'b1;
      end
    end else begin
      col_d = col_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) state_d = FILL;
        else          state_d = IDLE;
      end
      FILL: begin
        if (wrap_s && (row_q == ROW_ONE)) state_d = STREAM;
        else                              state_d = FILL;
      end
      STREAM: begin
        if (wrap_s && row_last_s) begin
`ifdef HYSTER_FEEDER_ROWPAD_EN
          state_d = FLUSH;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = STREAM;
        end
      end
      FLUSH: begin
        if (col_last_s) state_d = DONE;
        else            state_d = FLUSH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; pixels read as zero when no triple is emitted.
  always_comb begin
    out_valid_d  = stream_emit_s | pad_top_s | flush_s;
    strip_end_d  = out_valid_d & col_last_s;
    // Timed off the registered state so the pulse trails the last triple.
    frame_done_d = (state_q == DONE);
    in_ready_d   = (state_d == IDLE) || (state_d == FILL) || (state_d == STREAM);
    if (out_valid_d && !pad_top_s) pix0_d = top_rd_s;
    else                           pix0_d = PIX_ZERO;
    if (out_valid_d)               pix1_d = mid_rd_s;
    else                           pix1_d = PIX_ZERO;
    if (out_valid_d && !flush_s)   pix2_d = in_pixel_i;
    else                           pix2_d = PIX_ZERO;
  end

  // State, counter and output registers.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      col_q        <= {CW{1'b0}};
      row_q        <= {RW{1'b0}};
      top_sel_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      strip_end_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pix0_q       <= PIX_ZERO;
      pix1_q       <= PIX_ZERO;
      pix2_q       <= PIX_ZERO;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      top_sel_q    <= top_sel_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      strip_end_q  <= strip_end_d;
      frame_done_q <= frame_done_d;
      pix0_q       <= pix0_d;
      pix1_q       <= pix1_d;
      pix2_q       <= pix2_d;
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign strip_end_o  = strip_end_q;
  assign frame_done_o = frame_done_q;
  assign pixel_out0_o = pix0_q;
  assign pixel_out1_o = pix1_q;
  assign pixel_out2_o = pix2_q;

endmodule

// File: tb/tb_hyster_row_feeder.sv
// Bench for hyster_row_feeder at IMG_W=IMG_H=4, pixel = 4*row + col.
// Expected triples are queued with their due cycle when pixels are
// accepted; a monitor pops and compares them as the DUT emits.
`timescale 1ns/1ps
module tb_hyster_row_feeder;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 5;
`ifdef HYSTER_FEEDER_ROWPAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int TPF  = PAD ? W * H : (H - 2) * W;  // triples per frame
  localparam int RLPF = PAD ? W + 1 : 1;            // ready-low cycles per frame

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready_o, out_valid_o, strip_end_o, frame_done_o;
  logic [PW-1:0] pixel_out0_o, pixel_out1_o, pixel_out2_o;

  hyster_row_feeder #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk_p_i      (clk),
    .reset_n_i    (rst_n),
    .in_pixel_i   (in_pixel),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_o),
    .pixel_out0_o (pixel_out0_o),
    .pixel_out1_o (pixel_out1_o),
    .pixel_out2_o (pixel_out2_o),
    .out_valid_o  (out_valid_o),
    .strip_end_o  (strip_end_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p0; int p1; int p2; bit strip; bit last; int due;
  } trip_t;

  typedef struct {
    int gap; int nframes; int exp_trip; int exp_done; int exp_rdylow;
  } scen_t;

  trip_t exp_q[$];
  int    checks = 0, failures = 0;
  int    cyc = 0, done_due = -100;
  int    n_trip = 0, n_done = 0, rdy_low = 0;
  bit    win = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic trip_t mk(int p0, int p1, int p2, bit strip, bit last, int due);
    trip_t t;
    t.p0 = p0; t.p1 = p1; t.p2 = p2; t.strip = strip; t.last = last; t.due = due;
    return t;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  // Every cycle: valid/timing, triple contents, frame_done, ready-low count.
  task automatic monitor();
    trip_t e;
    bit    ev;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("out_valid", int'(out_valid_o), int'(ev));
      if (ev) begin
        e = exp_q.pop_front();
        if (out_valid_o) begin
          n_trip++;
          chk("pix_top", int'(pixel_out0_o), e.p0);
          chk("pix_mid", int'(pixel_out1_o), e.p1);
          chk("pix_bot", int'(pixel_out2_o), e.p2);
          chk("strip_end", int'(strip_end_o), int'(e.strip));
        end
        if (e.last) done_due = cyc + 1;
      end
      chk("frame_done", int'(frame_done_o), int'(cyc == done_due));
      if (frame_done_o) n_done++;
      if (win && !in_ready_o) rdy_low++;
    end
  endtask

  task automatic push_expect(input int r, input int c);
    if (r >= 2)
      exp_q.push_back(mk(4*(r-2)+c, 4*(r-1)+c, 4*r+c, c == W-1,
                         !PAD && r == H-1 && c == W-1, cyc));
    else if (PAD && r == 1)
      exp_q.push_back(mk(0, c, 4+c, c == W-1, 1'b0, cyc));
    if (PAD && r == H-1 && c == W-1)
      for (int k = 0; k < W; k++)
        exp_q.push_back(mk(4*(H-2)+k, 4*(H-1)+k, 0, k == W-1, k == W-1, cyc+1+k));
  endtask

  // Present one pixel and hold it until the DUT takes it.
  task automatic send_pix(input int r, input int c);
    bit rdy, took;
    in_valid = 1'b1;
    in_pixel = PW'(4*r + c);
    took = 1'b0;
    for (int t = 0; t < 20 && !took; t++) begin
      @(negedge clk);
      rdy = in_ready_o;
      @(posedge clk); #1;
      if (rdy) took = 1'b1;
    end
    if (took) push_expect(r, c);
    else chk("accept_timeout", 0, 1);
  endtask

  task automatic send_rows(input int gap, input int npix);
    for (int i = 0; i < npix; i++) begin
      send_pix(i / W, i % W);
      if (gap == 1) begin
        in_valid = 1'b0; @(posedge clk); #1;
      end else if (gap == 2) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && exp_q.size() > 0; t++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  scen_t tbl[4];

  initial begin
    int t0, d0;
    tbl[0] = '{0, 1, TPF,     1, RLPF};      // contiguous frame
    tbl[1] = '{1, 1, TPF,     1, RLPF};      // alternate-cycle gaps
    tbl[2] = '{2, 1, TPF,     1, RLPF};      // random gaps
    tbl[3] = '{0, 2, 2 * TPF, 2, 2 * RLPF};  // back-to-back frames

    fork monitor(); join_none

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'({in_ready_o, out_valid_o, pixel_out0_o, pixel_out1_o,
                               pixel_out2_o, strip_end_o, frame_done_o}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", int'(in_ready_o), 1);

    foreach (tbl[i]) begin
      t0 = n_trip; d0 = n_done; rdy_low = 0; win = 1'b1;
      for (int f = 0; f < tbl[i].nframes; f++) send_rows(tbl[i].gap, W * H);
      drain();
      win = 1'b0;
      chk($sformatf("scen%0d_triples", i), n_trip - t0, tbl[i].exp_trip);
      chk($sformatf("scen%0d_frame_done", i), n_done - d0, tbl[i].exp_done);
      chk($sformatf("scen%0d_ready_low", i), rdy_low, tbl[i].exp_rdylow);
    end

    // Reset in the middle of row 2, just before col 1 is presented.
    send_rows(0, 2 * W + 1);
    drain();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", int'({in_ready_o, out_valid_o, pixel_out0_o, pixel_out1_o,
                                  pixel_out2_o, strip_end_o, frame_done_o}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset_ready", int'(in_ready_o), 1);
    t0 = n_trip; d0 = n_done;
    send_rows(0, W * H);
    drain();
    chk("midreset_triples", n_trip - t0, TPF);
    chk("midreset_frame_done", n_done - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
